present80_wb_ctrl: RTL
======================

# present80_wb_ctrl

Wishbone-slave controller that sequences the PRESENT-80 round datapath inside the Caravel user project area. Firmware, or an mprj_io start button, loads an 80-bit key and a 64-bit plaintext, starts an encryption, and reads back the ciphertext. The block owns the cipher state, the round-key registers and the round counter. It drives the external combinational round/key-schedule datapath one round per clock and exposes status on the LED pins.

## Interface
- BASE_ADDR, 32'h3000_0000, Wishbone window base; decode on wbs_adr_i[31:8].
- wb_clk_i  in  1  single clock; all state on its rising edge.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic strobes.
- wbs_sel_i  in  4  byte lanes; writes honour the lanes.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_dat_o  out  32  read data; 0 when not acking.
- wbs_ack_o  out  1  one-cycle acknowledge.
- start_btn_i  in  1  asynchronous button (mprj_io[7]).
- leds_o  out  8  {busy, done, ct[5:0]}.
- state_o  out  64  current cipher state to datapath.
- rkey_o  out  80  current key register to datapath.
- rnd_o  out  5  round counter (1..31) to datapath.
- state_nxt_i  in  64  pLayer(sBox(state_o ^ rkey_o[79:16])).
- rkey_nxt_i  in  80  next key-schedule value for rnd_o.
- irq_o  out  1  done interrupt (PRESENT_IRQ_EN only).

## Operation
- Registers (offsets from BASE_ADDR):
  - 0x00 CTRL/STATUS: W bit0 START (self-clearing), W1C bit9 DONE, RW bit1 IRQ_EN; R bit8 BUSY, bit9 DONE.
  - 0x04/0x08/0x0C KEY0/KEY1/KEY2 (KEY2 uses [15:0]).
  - 0x10/0x14 PT0/PT1.
  - 0x18/0x1C CT0/CT1 (read-only).
- Reads of any other in-window offset return 0 and are acked. Out-of-window accesses are never acked.
- Writes to KEY/PT while BUSY are acked and dropped. START while BUSY is ignored.
- FSM:
  - IDLE: on start (CTRL write with bit0=1, or a synchronized button rising edge), load state←PT, key←KEY, rnd←1, done←0, and go to ROUND.
  - ROUND: each cycle state←state_nxt_i, key←rkey_nxt_i, rnd←rnd+1. When rnd==31, apply that update and go to FINAL.
  - FINAL: ct←state ^ key[79:16], done←1, go to IDLE.
- busy = (FSM != IDLE).
- Button path: 2-FF synchronizer plus rising-edge detect. A button edge and a CTRL START on the same cycle produce one start.

## Timing
- Reset values: all registers, ct, done, IRQ_EN, rnd, state_o, rkey_o = 0; FSM=IDLE; wbs_ack_o=0; leds_o=0; irq_o=0.
- Wishbone ack:
  - Asserts on the edge after cyc&stb is sampled with no ack pending. Held one cycle, then low for at least one cycle.
  - Write side effects commit on the same edge ack rises. Read data is valid while ack is high.
- Encryption latency, with start committed at edge E0:
  - E1..E31 perform rounds 1..31.
  - E32 latches CT and sets DONE, and BUSY drops.
  - A new start is accepted from E33.
- A DONE W1C on the same edge as the FINAL update leaves DONE=1 (set wins).
- Start clears DONE on its commit edge.
- Button-to-start latency: 3 cycles after the input rises.
- Reset asserted mid-encryption aborts immediately: FSM to IDLE, all registers cleared, no DONE.

## Configuration
- PRESENT_IRQ_EN defined:
  - irq_o = done & IRQ_EN, registered. It rises the cycle after DONE sets and falls the cycle after DONE clears.
- PRESENT_IRQ_EN undefined:
  - irq_o is not present.
  - CTRL bit1 reads 0 and writes to it are ignored.

## Test plan
- Reset: hold wb_rst_ni low mid-transaction -> all outputs 0, wbs_ack_o=0, CT reads 0x0 after release.
- Vector: KEY=0, PT=0, START -> BUSY=1 for exactly 32 cycles. DONE=1, CT1:CT0 = 5579C138_7B228445. Bench uses a behavioural round model on state_nxt_i/rkey_nxt_i.
- Vector: KEY=all F, PT=all F, START via start_btn_i -> CT = 3333DCD3_213210D2, leds_o[7:6]=01, leds_o[5:0]=0x12.
- Busy protection: write PT0=0xDEADBEEF and a second START during round 10 -> both acked. Result equals the original vector, and PT0 reads the old value.
- Bus edge cases:
  - Read 0x20 -> 0 with ack.
  - Address 0x3000_0100 -> no ack within 16 cycles.
  - DONE W1C on the DONE-set edge -> DONE reads 1.
- PRESENT_IRQ_EN: IRQ_EN=1, run KEY=all F, PT=0 -> CT=E72C46C0_F5945049 and irq_o high one cycle after DONE. W1C DONE -> irq_o low the next cycle.

Source files
------------

// File: rtl/present80_wb_ctrl.sv
// present80_wb_ctrl: Wishbone-slave sequencer for an external PRESENT-80 round datapath.
// Ports: wb_clk_i/wb_rst_ni, Wishbone slave (wbs_*), start_btn_i, leds_o {busy,done,ct[5:0]},
// datapath taps state_o/rkey_o/rnd_o out and state_nxt_i/rkey_nxt_i in,
// irq_o only when PRESENT_IRQ_EN is defined (also gates CTRL bit1 IRQ_EN).
module present80_wb_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  input  logic        start_btn_i,
  output logic [7:0]  leds_o,
  output logic [63:0] state_o,
  output logic [79:0] rkey_o,
  output logic [4:0]  rnd_o,
  input  logic [63:0] state_nxt_i,
  input  logic [79:0] rkey_nxt_i
`ifdef PRESENT_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_FINAL
  } fsm_e;

  fsm_e        fsm_q, fsm_d;
  logic [63:0] state_q, state_d;
  logic [79:0] rkey_q, rkey_d;
  logic [4:0]  rnd_q, rnd_d;
  logic [63:0] ct_q, ct_d;
  logic        done_q, done_d;
  logic [31:0] key0_q, key0_d;
  logic [31:0] key1_q, key1_d;
  logic [15:0] key2_q, key2_d;
  logic [31:0] pt0_q, pt0_d;
  logic [31:0] pt1_q, pt1_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        btn_s1_q, btn_s2_q, btn_prev_q;
  logic        irq_en_rd;

  logic        hit, req, wr, rd;
  logic [5:0]  off;
  logic        wr_ctrl;
  logic        busy;
  logic        btn_rise;
  logic        start;
  logic [31:0] rdata;
  logic [31:0] k2_wide;
  logic        unused_adr;

  function automatic logic [31:0] merge_be(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    end
    return r;
  endfunction

  assign unused_adr = ^wbs_adr_i[1:0];

  assign busy     = (fsm_q != S_IDLE);
  assign hit      = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  // ~ack_q forces a gap cycle between back-to-back acks
  assign req      = wbs_cyc_i & wbs_stb_i & hit & ~ack_q;
  assign wr       = req & wbs_we_i;
  assign rd       = req & ~wbs_we_i;
  assign off      = wbs_adr_i[7:2];
  assign wr_ctrl  = wr && (off == 6'h00);
  assign btn_rise = btn_s2_q & ~btn_prev_q;
  // button edge and CTRL start OR together, so a coincidence is one start
  assign start    = ((wr_ctrl & wbs_sel_i[0] & wbs_dat_i[0]) | btn_rise) & ~busy;
  assign k2_wide  = {16'h0, key2_q};

`ifdef PRESENT_IRQ_EN
  logic irq_en_q, irq_en_d;
  logic irq_q;

  always_comb begin
    irq_en_d = irq_en_q;
    if (wr_ctrl && wbs_sel_i[0]) irq_en_d = wbs_dat_i[1];
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= done_q & irq_en_q;
    end
  end

  assign irq_en_rd = irq_en_q;
  assign irq_o     = irq_q;
`else
  assign irq_en_rd = 1'b0;
`endif

  // register file writes; KEY/PT are frozen while an encryption runs
  always_comb begin
    key0_d = key0_q;
    key1_d = key1_q;
    key2_d = key2_q;
    pt0_d  = pt0_q;
    pt1_d  = pt1_q;
    if (wr && !busy) begin
      case (off)
        6'h01:   key0_d = merge_be(key0_q, wbs_dat_i, wbs_sel_i);
        6'h02:   key1_d = merge_be(key1_q, wbs_dat_i, wbs_sel_i);
        6'h03:   key2_d = merge_be(k2_wide, wbs_dat_i, wbs_sel_i)
                          [15:0];
        6'h04:   pt0_d  = merge_be(pt0_q, wbs_dat_i, wbs_sel_i);
        6'h05:   pt1_d  = merge_be(pt1_q, wbs_dat_i, wbs_sel_i);
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = 32'h0;
    case (off)
      6'h00:   rdata = {22'h0, done_q, busy, 6'h0, irq_en_rd, 1'b0};
      6'h01:   rdata = key0_q;
      6'h02:   rdata = key1_q;
      6'h03:   rdata = k2_wide;
      6'h04:   rdata = pt0_q;
      6'h05:   rdata = pt1_q;
      6'h06:   rdata = ct_q[31:0];
      6'h07:   rdata = ct_q[63:32];
      default: rdata = 32'h0;
    endcase
    ack_d = req;
    dat_d = rd ? rdata : 32'h0;
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rkey_d  = rkey_q;
    rnd_d   = rnd_q;
    ct_d    = ct_q;
    done_d  = done_q;
    if (wr_ctrl && wbs_sel_i[1] && wbs_dat_i[9]) done_d = 1'b0;
    unique case (fsm_q)
      S_IDLE: begin
        if (start) begin
          state_d = {pt1_q, pt0_q};
          rkey_d  = {key2_q, key1_q, key0_q};
          rnd_d   = 5'd1;
          done_d  = 1'b0;
          fsm_d   = S_ROUND;
        end
      end
      S_ROUND: begin
        state_d = state_nxt_i;
        rkey_d  = rkey_nxt_i;
        rnd_d   = rnd_q + 5'd1;
        if (rnd_q == 5'd31) fsm_d = S_FINAL;
      end
      S_FINAL: begin
        // post-whitening with K32; set beats a same-edge W1C
        ct_d   = state_q ^ rkey_q[79:16];
        done_d = 1'b1;
        fsm_d  = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      fsm_q      <= S_IDLE;
      state_q    <= 64'h0;
      rkey_q     <= 80'h0;
      rnd_q      <= 5'd0;
      ct_q       <= 64'h0;
      done_q     <= 1'b0;
      key0_q     <= 32'h0;
      key1_q     <= 32'h0;
      key2_q     <= 16'h0;
      pt0_q      <= 32'h0;
      pt1_q      <= 32'h0;
      ack_q      <= 1'b0;
      dat_q      <= 32'h0;
      btn_s1_q   <= 1'b0;
      btn_s2_q   <= 1'b0;
      btn_prev_q <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      state_q    <= state_d;
      rkey_q     <= rkey_d;
      rnd_q      <= rnd_d;
      ct_q       <= ct_d;
      done_q     <= done_d;
      key0_q     <= key0_d;
      key1_q     <= key1_d;
      key2_q     <= key2_d;
      pt0_q      <= pt0_d;
      pt1_q      <= pt1_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      btn_s1_q   <= start_btn_i;
      btn_s2_q   <= btn_s1_q;
      btn_prev_q <= btn_s2_q;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign leds_o    = {busy, done_q, ct_q[5:0]};
  assign state_o   = state_q;
  assign rkey_o    = rkey_q;
  assign rnd_o     = rnd_q;

endmodule
